// File: rtl/pll_phase_ctrl_if.sv
// Request/status bundle between the config register block and the PLL phase controller.
// The master side issues phase requests; the slave side is the controller.
interface pll_phase_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_chan;
    logic [7:0] req_phase;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cur_phase;

    modport master (
        output req_valid, req_chan, req_phase,
        input  req_ready, busy, done, err, cur_phase
    );

    modport slave (
        input  req_valid, req_chan, req_phase,
        output req_ready, busy, done, err, cur_phase
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// Moves a PLL output clock to an absolute phase by sequencing PSSEL/PSDIR/PSPULSE,
// tracking each CLKOUT's phase and always taking the shorter way around the circle.
module pll_phase_ctrl #(
    parameter int PHASE_N   = 80,
    parameter int INIT_PH2  = 52,
    parameter int SETUP_CYC = 4,
    parameter int HI_CYC    = 4,
    parameter int GAP_CYC   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    pll_phase_ctrl_if.slave  req,
    output logic [2:0]       pssel,
    output logic             psdir,
    output logic             pspulse
);

    localparam int TMAX = (SETUP_CYC > HI_CYC) ?
                          ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                          ((HI_CYC > GAP_CYC) ? HI_CYC : GAP_CYC);
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [8:0] PN9   = 9'(PHASE_N);
    localparam logic [8:0] HALF9 = 9'(PHASE_N / 2);
    localparam logic [7:0] PMAX8 = 8'(PHASE_N - 1);
    localparam logic [7:0] INIT8 = 8'(INIT_PH2);

    localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] T_HI    = TW'(HI_CYC - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PHI,
        S_PLO,
        S_DONE
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer, next_timer;
    logic [7:0]    count, next_count;
    logic [1:0]    chan;
    logic [7:0]    ph [4];

    logic          load_req;
    logic          load_dir;
    logic          next_dir;
    logic          step_en;
    logic          set_err;
    logic [8:0]    diff_raw;
    logic [8:0]    diff;
    logic [8:0]    far;
    logic [7:0]    cur_ph;
    logic [7:0]    stepped;

    assign req.req_ready = (state == S_IDLE) && pll_lock && !reset;
    assign req.cur_phase = ph[req.req_chan];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: shortest-path planning on accept, then pulse pacing
    always_comb begin
        next_state = state;
        next_timer = (timer == '0) ? timer : timer - 1'b1;
        next_count = count;
        next_dir   = psdir;
        load_req   = 1'b0;
        load_dir   = 1'b0;
        step_en    = 1'b0;
        set_err    = 1'b0;

        diff_raw = {1'b0, req.req_phase} + PN9 - {1'b0, ph[req.req_chan]};
        diff     = (diff_raw >= PN9) ? diff_raw - PN9 : diff_raw;
        far      = PN9 - diff;

        case (state)
            S_IDLE: begin
                if (req.req_valid && req.req_ready) begin
                    load_req = 1'b1;
                    if ({1'b0, req.req_phase} >= PN9) begin
                        next_state = S_DONE;
                        set_err    = 1'b1;
                    end else if (diff == '0) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_SETUP;
                        next_timer = T_SETUP;
                        load_dir   = 1'b1;
                        if (diff <= HALF9) begin
                            next_dir   = 1'b0;
                            next_count = diff[7:0];
                        end else begin
                            next_dir   = 1'b1;
                            next_count = far[7:0];
                        end
                    end
                end
            end
            S_SETUP: begin
                if (!pll_lock) begin
                    next_state = S_DONE;
                    set_err    = 1'b1;
                end else if (timer == '0) begin
                    next_state = S_PHI;
                    next_timer = T_HI;
                end
            end
            S_PHI: begin
                // An interrupted pulse is treated as a completed step
                if (!pll_lock) begin
                    step_en    = 1'b1;
                    next_state = S_DONE;
                    set_err    = 1'b1;
                end else if (timer == '0) begin
                    next_state = S_PLO;
                    next_timer = T_GAP;
                end
            end
            S_PLO: begin
                // The falling edge into PLO already moved the PLL, so book the step here
                if (timer == T_GAP) begin
                    step_en    = 1'b1;
                    next_count = count - 8'd1;
                end
                if (!pll_lock) begin
                    next_state = S_DONE;
                    set_err    = 1'b1;
                end else if (timer == '0) begin
                    if (next_count == '0) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_PHI;
                        next_timer = T_HI;
                    end
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cur_ph = ph[chan];
        if (psdir) begin
            stepped = (cur_ph == '0) ? PMAX8 : cur_ph - 8'd1;
        end else begin
            stepped = (cur_ph == PMAX8) ? '0 : cur_ph + 8'd1;
        end
    end

    // Datapath and registered outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            timer    <= '0;
            count    <= '0;
            chan     <= '0;
            pssel    <= '0;
            psdir    <= 1'b0;
            pspulse  <= 1'b0;
            req.busy <= 1'b0;
            req.done <= 1'b0;
            req.err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ph[i] <= (i == 2) ? INIT8 : '0;
            end
        end else begin
            timer    <= next_timer;
            count    <= next_count;
            pspulse  <= (next_state == S_PHI);
            req.busy <= (next_state == S_SETUP) || (next_state == S_PHI) ||
                        (next_state == S_PLO);
            req.done <= (next_state == S_DONE);
            req.err  <= (next_state == S_DONE) && set_err;
            if (load_req) begin
                chan  <= req.req_chan;
                pssel <= {1'b0, req.req_chan};
            end
            if (load_dir) begin
                psdir <= next_dir;
            end
            if (step_en) begin
                ph[chan] <= stepped;
            end
        end
    end

endmodule
